// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU control path and the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_en;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              stall;
  logic              addr_err;

  modport master (
    output mem_en, mem_write, addr, wdata,
    input  rdata, ack, stall, addr_err
  );

  modport slave (
    input  mem_en, mem_write, addr, wdata,
    output rdata, ack, stall, addr_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory serving one LW/SW request at a time after WAIT
// wait states; stalls the pipeline while busy and pulses ack on completion.
module dmem_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WAIT   = 2
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'((WAIT == 0) ? 0 : WAIT - 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_write;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    addr_err_d = 1'b0;
    acc        = 1'b0;
    acc_addr   = addr_q;
    acc_data   = wdata_q;
    acc_write  = write_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_en) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          write_d = bus.mem_write;
          if (WAIT == 0) begin
            // Zero wait states: the access uses the request being latched on this edge.
            state_d   = ST_RESP;
            acc       = 1'b1;
            acc_addr  = bus.addr;
            acc_data  = bus.wdata;
            acc_write = bus.mem_write;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          acc     = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_range = ({1'b0, acc_addr} < DEPTH_L);
    idx      = acc_addr[IDX_W-1:0];

    if (acc) begin
      ack_d      = 1'b1;
      addr_err_d = ~in_range;
      if (!acc_write) begin
        rdata_d = in_range ? mem[idx] : '0;
      end
    end

    // Out-of-range writes are dropped rather than wrapped onto a low address.
    mem_we = acc & acc_write & in_range & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= acc_data;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.addr_err = addr_err_q;
  assign bus.stall    = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && bus.mem_en);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance driven from a vector
// table plus hand sequences, and a WAIT=0 instance for the zero-latency path.
module tb_dmem_responder;

  localparam int unsigned W2 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) b0 ();

  assign b2.mem_en    = mem_en & ~sel;
  assign b2.mem_write = mem_write;
  assign b2.addr      = addr;
  assign b2.wdata     = wdata;
  assign b0.mem_en    = mem_en & sel;
  assign b0.mem_write = mem_write;
  assign b0.addr      = addr;
  assign b0.wdata     = wdata;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave)
  );
  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );

  logic [15:0] rdata_m;
  logic        ack_m, stall_m, err_m;
  assign rdata_m = sel ? b0.rdata    : b2.rdata;
  assign ack_m   = sel ? b0.ack      : b2.ack;
  assign stall_m = sel ? b0.stall    : b2.stall;
  assign err_m   = sel ? b0.addr_err : b2.addr_err;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rd;
    logic        err;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic do_req(input string tag, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic corrupt,
                        input logic [15:0] exp_rd, input logic exp_err);
    int  k;
    bit  got;
    int  exp_lat;
    exp_lat   = sel ? 0 : int'(W2);
    mem_write = we;
    addr      = a;
    wdata     = d;
    mem_en    = 1'b1;
    #1 check({tag, ".stall_req"}, 32'(stall_m), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0;
    if (corrupt) begin
      addr      = a + 16'd1;
      wdata     = 16'hFFFF;
      mem_write = ~we;
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      if (ack_m) begin
        got = 1'b1;
      end else begin
        check({tag, ".stall_wait"}, 32'(stall_m), 32'd1);
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
    check({tag, ".latency"}, got ? 32'(k) : 32'hDEAD, 32'(exp_lat));
    check({tag, ".stall_resp"}, 32'(stall_m), 32'd0);
    check({tag, ".addr_err"}, 32'(err_m), 32'(exp_err));
    check({tag, ".rdata"}, 32'(rdata_m), 32'(exp_rd));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".ack_once"}, 32'(ack_m), 32'd0);
    check({tag, ".err_clr"}, 32'(err_m), 32'd0);
  endtask

  initial begin
    int t1, t2, nack;
    logic [15:0] rd1, rd2;

    vt[0]  = '{1'b1, 16'd5,   16'h1234, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 16'd5,   16'h0000, 16'h1234, 1'b0};
    vt[2]  = '{1'b1, 16'd44,  16'h0044, 16'h1234, 1'b0};
    vt[3]  = '{1'b1, 16'd300, 16'hBEEF, 16'h1234, 1'b1};
    vt[4]  = '{1'b0, 16'd44,  16'h0000, 16'h0044, 1'b0};
    vt[5]  = '{1'b0, 16'd300, 16'h0000, 16'h0000, 1'b1};
    vt[6]  = '{1'b1, 16'd1,   16'h0011, 16'h0000, 1'b0};
    vt[7]  = '{1'b1, 16'd2,   16'h0022, 16'h0000, 1'b0};
    vt[8]  = '{1'b1, 16'd9,   16'h0009, 16'h0000, 1'b0};
    vt[9]  = '{1'b1, 16'd255, 16'h00FF, 16'h0000, 1'b0};
    vt[10] = '{1'b0, 16'd255, 16'h0000, 16'h00FF, 1'b0};
    vt[11] = '{1'b1, 16'd7,   16'h0777, 16'h00FF, 1'b0};
    vt[12] = '{1'b0, 16'd256, 16'h0000, 16'h0000, 1'b1};
    vt[13] = '{1'b0, 16'd9,   16'h0000, 16'h0009, 1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.ack", 32'(ack_m), 32'd0);
    check("reset.stall", 32'(stall_m), 32'd0);
    check("reset.rdata", 32'(rdata_m), 32'd0);
    check("reset.addr_err", 32'(err_m), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].we, vt[i].a, vt[i].d, 1'b0, vt[i].rd, vt[i].err);
    end

    // Inputs changed after acceptance must not disturb the latched write.
    do_req("late_chg.wr", 1'b1, 16'd6, 16'hAAAA, 1'b1, 16'h0009, 1'b0);
    do_req("late_chg.rd6", 1'b0, 16'd6, 16'h0000, 1'b0, 16'hAAAA, 1'b0);
    do_req("late_chg.rd7", 1'b0, 16'd7, 16'h0000, 1'b0, 16'h0777, 1'b0);

    // Back-to-back reads with mem_en held high.
    mem_write = 1'b0;
    addr      = 16'd1;
    mem_en    = 1'b1;
    nack = 0; t1 = 0; t2 = 0; rd1 = '0; rd2 = '0;
    for (int n = 0; n < 30 && nack < 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (nack == 1 && !ack_m && t2 == 0 && cyc == t1 + 1) begin
        check("b2b.idle_stall", 32'(stall_m), 32'd1);
      end
      if (ack_m) begin
        nack++;
        if (nack == 1) begin
          t1   = cyc;
          rd1  = rdata_m;
          addr = 16'd2;
        end else begin
          t2     = cyc;
          rd2    = rdata_m;
          mem_en = 1'b0;
        end
      end
    end
    mem_en = 1'b0;
    check("b2b.acks", 32'(nack), 32'd2);
    check("b2b.spacing", 32'(t2 - t1), 32'd4);
    check("b2b.rd1", 32'(rd1), 32'h0011);
    check("b2b.rd2", 32'(rd2), 32'h0022);
    @(posedge clk);
    @(negedge clk);

    // Reset during the last wait cycle of a write.
    mem_write = 1'b1;
    addr      = 16'd9;
    wdata     = 16'h5555;
    mem_en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.ack", 32'(ack_m), 32'd0);
    check("rst_mid.stall", 32'(stall_m), 32'd0);
    check("rst_mid.rdata", 32'(rdata_m), 32'd0);
    check("rst_mid.addr_err", 32'(err_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req("rst_mid.rd9", 1'b0, 16'd9, 16'h0000, 1'b0, 16'h0009, 1'b0);
    do_req("rst_mid.rd5", 1'b0, 16'd5, 16'h0000, 1'b0, 16'h1234, 1'b0);

    // Zero wait-state instance.
    sel = 1'b1;
    #1;
    do_req("w0.wr3", 1'b1, 16'd3, 16'h0333, 1'b0, 16'h0000, 1'b0);
    do_req("w0.rd3", 1'b0, 16'd3, 16'h0000, 1'b0, 16'h0333, 1'b0);
    do_req("w0.rd400", 1'b0, 16'd400, 16'h0000, 1'b0, 16'h0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
